// File: rtl/life_manager_if.sv
// Bus between the life manager and the game/HUD logic.
// The game side drives hit and restart; the manager drives the
// life-count and status outputs consumed by the HUD and gameplay.
interface life_manager_if;
  logic       hit;
  logic       restart;
  logic [8:0] dead_times;
  logic [1:0] lives_left;
  logic       dying;
  logic       invuln;
  logic       respawn;
  logic       game_over;

  // Game-state / HUD side
  modport master (
    output hit,
    output restart,
    input  dead_times,
    input  lives_left,
    input  dying,
    input  invuln,
    input  respawn,
    input  game_over
  );

  // Life manager side
  modport slave (
    input  hit,
    input  restart,
    output dead_times,
    output lives_left,
    output dying,
    output invuln,
    output respawn,
    output game_over
  );
endinterface

// File: rtl/life_manager.sv
// Per-player lives and death-sequence controller.
// dead_times accumulates death-animation frames. Each death runs the
// counter up to the next icon threshold. lives_left is the number of
// thresholds not yet reached. Frame pacing comes from a synchronized
// frame_clk rising-edge detector running in the Clk domain.
module life_manager #(
  parameter int THRESH_A      = 10,
  parameter int THRESH_B      = 60,
  parameter int THRESH_C      = 250,
  parameter int INVULN_FRAMES = 120
) (
  input logic          Clk,
  input logic          Reset,
  input logic          frame_clk,
  life_manager_if.slave bus
);

  localparam logic [8:0] THR_A    = 9'(THRESH_A);
  localparam logic [8:0] THR_B    = 9'(THRESH_B);
  localparam logic [8:0] THR_C    = 9'(THRESH_C);
  localparam logic [8:0] DT_MAX   = 9'd511;
  localparam logic [7:0] INV_LOAD = 8'(INVULN_FRAMES);

  typedef enum logic [2:0] {
    ST_ALIVE,
    ST_DYING,
    ST_RESPAWN,
    ST_INVULN,
    ST_GAME_OVER
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] dead_times_q, dead_times_d;
  logic [8:0] target_q, target_d;
  logic [7:0] invuln_cnt_q, invuln_cnt_d;
  logic       respawn_q, respawn_d;

  logic       frame_sync1, frame_sync2, frame_prev;
  logic       frame_tick;
  logic [8:0] dead_times_inc;
  logic [8:0] next_target;

  // Two-flop synchronizer plus a previous-value flop for edge detection
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_sync1 <= 1'b0;
      frame_sync2 <= 1'b0;
      frame_prev  <= 1'b0;
    end else begin
      frame_sync1 <= frame_clk;
      frame_sync2 <= frame_sync1;
      frame_prev  <= frame_sync2;
    end
  end

  assign frame_tick = frame_sync2 & ~frame_prev;

  // Saturating increment and the next icon threshold above the current count
  always_comb begin
    dead_times_inc = (dead_times_q == DT_MAX) ? DT_MAX : dead_times_q + 9'd1;
    if (dead_times_q < THR_A) begin
      next_target = THR_A;
    end else if (dead_times_q < THR_B) begin
      next_target = THR_B;
    end else begin
      next_target = THR_C;
    end
  end

  // Register the state, counters and the respawn pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_ALIVE;
      dead_times_q <= 9'd0;
      target_q     <= 9'd0;
      invuln_cnt_q <= 8'd0;
      respawn_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dead_times_q <= dead_times_d;
      target_q     <= target_d;
      invuln_cnt_q <= invuln_cnt_d;
      respawn_q    <= respawn_d;
    end
  end

  // Next-state and datapath updates; restart overrides everything else
  always_comb begin
    state_d      = state_q;
    dead_times_d = dead_times_q;
    target_d     = target_q;
    invuln_cnt_d = invuln_cnt_q;
    respawn_d    = 1'b0;

    if (bus.restart) begin
      state_d      = ST_ALIVE;
      dead_times_d = 9'd0;
      target_d     = 9'd0;
      invuln_cnt_d = 8'd0;
      respawn_d    = 1'b1;
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (bus.hit) begin
            state_d  = ST_DYING;
            target_d = next_target;
          end
        end

        ST_DYING: begin
          if (frame_tick) begin
            dead_times_d = dead_times_inc;
            if (dead_times_inc == target_q) begin
              if (target_q == THR_C) begin
                state_d = ST_GAME_OVER;
              end else begin
                state_d   = ST_RESPAWN;
                respawn_d = 1'b1;
              end
            end
          end
        end

        ST_RESPAWN: begin
          invuln_cnt_d = INV_LOAD;
          state_d      = ST_INVULN;
        end

        ST_INVULN: begin
          if (frame_tick) begin
            if (invuln_cnt_q <= 8'd1) begin
              invuln_cnt_d = 8'd0;
              state_d      = ST_ALIVE;
            end else begin
              invuln_cnt_d = invuln_cnt_q - 8'd1;
            end
          end
        end

        ST_GAME_OVER: begin
          state_d = ST_GAME_OVER;
        end

        default: begin
          state_d = ST_ALIVE;
        end
      endcase
    end
  end

  assign bus.dead_times = dead_times_q;
  assign bus.lives_left = 2'(dead_times_q < THR_A)
                        + 2'(dead_times_q < THR_B)
                        + 2'(dead_times_q < THR_C);
  assign bus.dying      = (state_q == ST_DYING);
  assign bus.invuln     = (state_q == ST_INVULN);
  assign bus.game_over  = (state_q == ST_GAME_OVER);
  assign bus.respawn    = respawn_q;

endmodule
